// File: rtl/exp_calculator_vec_pkg.sv
// Shared constants for the vector exp(x) pipeline: Q-format widths, log2(e),
// and the 2^(-j/32) table used for the fractional power of two.
package exp_calculator_vec_pkg;

   localparam int Q12_FRAC      = 12;
   localparam int Q14_FRAC      = 14;
   localparam int Q16_FRAC      = 16;
   localparam int PIPE_STAGES   = 3;
   localparam int EXP2_IDX_BITS = 5;
   localparam int INTERP_BITS   = Q12_FRAC - EXP2_IDX_BITS;

   localparam logic [14:0] LOG2E_Q14 = 15'd23637;

   // 2^-1 in Q1.16: the right-hand neighbour of the last table entry.
   localparam logic [16:0] EXP2_HALF_Q16 = 17'd32768;

   // round(65536 * 2^(-j/32)), j = 0..31
   localparam logic [16:0] EXP2_TAB [32] = '{
      17'd65536, 17'd64132, 17'd62757, 17'd61413,
      17'd60097, 17'd58809, 17'd57549, 17'd56316,
      17'd55109, 17'd53928, 17'd52773, 17'd51642,
      17'd50535, 17'd49452, 17'd48393, 17'd47356,
      17'd46341, 17'd45348, 17'd44376, 17'd43425,
      17'd42495, 17'd41584, 17'd40693, 17'd39821,
      17'd38968, 17'd38133, 17'd37316, 17'd36516,
      17'd35734, 17'd34968, 17'd34219, 17'd33486
   };

endpackage

// File: rtl/exp_lane.sv
// Scalar 3-stage exp(x) datapath, Q4.12 in and out. Stage loads are gated by
// enables supplied by the parent, which owns all valid tracking.
module exp_lane
   import exp_calculator_vec_pkg::*;
#(
   parameter int W = 16
)
(
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_en1,
   input  logic         i_en2,
   input  logic         i_en3,
   input  logic [W-1:0] i_x,
   output logic [W-1:0] o_y
);

   localparam int TW = W + 2;
   localparam int KW = TW - Q12_FRAC;
   localparam logic [4:0] BASE_SH = 5'(Q16_FRAC - Q12_FRAC);

   logic [W:0]              w_neg;
   logic [W+15:0]           w_prod;
   logic [TW-1:0]           r_t;

   logic [KW-1:0]           w_k;
   logic [EXP2_IDX_BITS-1:0] w_j;
   logic [INTERP_BITS-1:0]  w_frac;
   logic [16:0]             w_hi;
   logic [16:0]             w_lo;
   logic [16:0]             w_diff;
   logic [23:0]             w_step;
   logic [16:0]             w_m;
   logic [KW-1:0]           r_k;
   logic [16:0]             r_m;

   logic                    w_big;
   logic [4:0]              w_sh;
   logic [19:0]             w_sum;
   logic [19:0]             w_y;
   logic [W-1:0]            r_y;

   // Stage 1: positive inputs clamp to 0, then t = -x * log2(e) in Q.12.
   assign w_neg  = i_x[W-1] ? (~{1'b1, i_x} + 1'b1) : '0;
   assign w_prod = {15'd0, w_neg} * {{(W+1){1'b0}}, LOG2E_Q14};

   // Stage 2: t = k + f; f's top bits index the table, low bits interpolate.
   assign w_k    = r_t[TW-1:Q12_FRAC];
   assign w_j    = r_t[Q12_FRAC-1 -: EXP2_IDX_BITS];
   assign w_frac = r_t[INTERP_BITS-1:0];
   assign w_hi   = EXP2_TAB[w_j];
   assign w_lo   = (w_j == 5'd31) ? EXP2_HALF_Q16 : EXP2_TAB[w_j + 5'd1];
   assign w_diff = w_hi - w_lo;
   assign w_step = {7'd0, w_diff} * {{(24-INTERP_BITS){1'b0}}, w_frac};
   assign w_m    = w_hi - w_step[INTERP_BITS +: 17];

   // Stage 3: Q1.16 -> Q.12 and divide by 2^k in one rounded shift.
   assign w_big = (r_k >= KW'(16));
   assign w_sh  = BASE_SH + {1'b0, r_k[3:0]};
   assign w_sum = {3'd0, r_m} + (20'd1 << (w_sh - 5'd1));
   assign w_y   = w_sum >> w_sh;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_t <= '0;
         r_k <= '0;
         r_m <= '0;
         r_y <= '0;
      end else begin
         if (i_en1) r_t <= w_prod[W+15:Q14_FRAC];
         if (i_en2) begin
            r_k <= w_k;
            r_m <= w_m;
         end
         if (i_en3) r_y <= w_big ? '0 : w_y[W-1:0];
      end
   end

   assign o_y = r_y;

endmodule

// File: rtl/exp_calculator_vec.sv
// N-lane fully pipelined exp(x) for softmax numerators: fixed 3-cycle latency,
// no stall. o_exp holds its last vector until the next o_valid pulse.
module exp_calculator_vec
   import exp_calculator_vec_pkg::*;
#(
   parameter int N         = 32,
   parameter int BIT_WIDTH = 16
)
(
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_valid,
   input  logic signed [N*BIT_WIDTH-1:0] i_data,
   output logic signed [N*BIT_WIDTH-1:0] o_exp,
   output logic                          o_valid
);

   // Bit s is the valid of the vector sitting in stage s+1's registers.
   logic [PIPE_STAGES-1:0] r_valid;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_valid <= '0;
      else       r_valid <= {r_valid[PIPE_STAGES-2:0], i_valid};
   end

   assign o_valid = r_valid[PIPE_STAGES-1];

   for (genvar g = 0; g < N; g++) begin : g_lane
      exp_lane #(.W(BIT_WIDTH)) u_lane (
         .i_clk (i_clk),
         .i_rst (i_rst),
         .i_en1 (i_valid),
         .i_en2 (r_valid[0]),
         .i_en3 (r_valid[1]),
         .i_x   (i_data[g*BIT_WIDTH +: BIT_WIDTH]),
         .o_y   (o_exp[g*BIT_WIDTH +: BIT_WIDTH])
      );
   end

endmodule

// File: tb/tb_exp_calculator_vec.sv
// Bench for exp_calculator_vec: directed corner vectors plus ramp and random
// streams checked against a real-valued exp() reference.
`timescale 1ns/1ps
module tb_exp_calculator_vec;

   localparam int N  = 32;
   localparam int BW = 16;
   localparam int VW = N * BW;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 in_valid = 1'b0;
   logic signed [VW-1:0] in_data = '0;
   logic signed [VW-1:0] out_exp;
   logic                 out_valid;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [VW-1:0] exp_q[$];
   int            stamp_q[$];

   exp_calculator_vec #(.N(N), .BIT_WIDTH(BW)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_valid (in_valid),
      .i_data  (in_data),
      .o_exp   (out_exp),
      .o_valid (out_valid)
   );

   always #5 clk = ~clk;

   // ---------------- reference model and helpers ----------------
   function automatic real ref_exp(input int x);
      real xr;
      xr = (x > 0) ? 0.0 : real'(x);
      return 4096.0 * $exp(xr / 4096.0);
   endfunction

   function automatic int lane_val(input logic [VW-1:0] v, input int i);
      logic signed [BW-1:0] s;
      s = v[i*BW +: BW];
      return int'(s);
   endfunction

   function automatic logic [VW-1:0] fill(input int x);
      logic [VW-1:0] v;
      for (int i = 0; i < N; i++) v[i*BW +: BW] = BW'(x);
      return v;
   endfunction

   function automatic logic [VW-1:0] random_vec();
      logic [VW-1:0] v;
      for (int i = 0; i < N; i++) v[i*BW +: BW] = BW'($urandom);
      return v;
   endfunction

   function automatic bit near(input int y, input real r);
      return (real'(y) - r <= 2.0) && (r - real'(y) <= 2.0);
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step();
      @(negedge clk);
      cyc++;
   endtask

   // Drives one vector, then garbage with i_valid low, and waits (bounded)
   // for the first o_valid; lat = -1 when none arrives.
   task automatic send_one(input logic [VW-1:0] v, output int lat, output logic [VW-1:0] got);
      int start;
      step();
      in_valid = 1'b1;
      in_data  = v;
      start    = cyc;
      step();
      in_valid = 1'b0;
      in_data  = random_vec();
      lat = -1;
      got = '0;
      for (int c = 0; c < 10 && lat < 0; c++) begin
         if (out_valid === 1'b1) begin
            lat = cyc - start;
            got = out_exp;
         end else begin
            step();
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #2 rst = 1'b1;
      #1;
      total++;
      if (out_valid !== 1'b0) begin
         bad++; $display("FAIL reset_valid: got %b want 0", out_valid);
      end
      total++;
      if (out_exp !== '0) begin
         bad++; $display("FAIL reset_exp: got %h want 0", out_exp);
      end
      repeat (2) step();
      rst = 1'b0;
   endtask

   task automatic test_zero();
      int lat, n;
      logic [VW-1:0] got;
      send_one(fill(0), lat, got);
      total++;
      if (lat !== 3) begin
         bad++; $display("FAIL zero_latency: got %0d want 3", lat);
      end
      total++;
      if (got !== fill(4096)) begin
         bad++; $display("FAIL zero_value: got %h want all 4096", got);
      end
      n = 0;
      repeat (10) begin
         step();
         if (out_valid === 1'b1) n++;
      end
      total++;
      if (n !== 0) begin
         bad++; $display("FAIL zero_extra_pulses: got %0d want 0", n);
      end
      total++;
      if (out_exp !== fill(4096)) begin
         bad++; $display("FAIL zero_hold: got %h want all 4096", out_exp);
      end
   endtask

   task automatic test_points();
      int pts  [4] = '{-2048, -4096, -8192, -32768};
      int want [4] = '{2484, 1507, 554, 1};
      int lat, y;
      logic [VW-1:0] v, got;
      for (int i = 0; i < N; i++) v[i*BW +: BW] = BW'(pts[i % 4]);
      send_one(v, lat, got);
      total++;
      if (lat !== 3) begin
         bad++; $display("FAIL points_latency: got %0d want 3", lat);
      end
      for (int i = 0; i < N; i++) begin
         y = lane_val(got, i);
         total++;
         if (y < 0 || !near(y, real'(want[i % 4]))) begin
            bad++; $display("FAIL points_const lane %0d: got %0d want %0d+/-2", i, y, want[i % 4]);
         end
         total++;
         if (!near(y, ref_exp(pts[i % 4]))) begin
            bad++; $display("FAIL points_model lane %0d: got %0d want %f+/-2", i, y, ref_exp(pts[i % 4]));
         end
      end
   endtask

   task automatic test_clamp();
      int lat, y;
      logic [VW-1:0] v, got;
      for (int i = 0; i < N; i++) begin
         case (i % 4)
            0:       v[i*BW +: BW] = 16'sd2048;
            1:       v[i*BW +: BW] = 16'sd32767;
            2:       v[i*BW +: BW] = BW'($urandom_range(1, 32767));
            default: v[i*BW +: BW] = '0;
         endcase
      end
      send_one(v, lat, got);
      total++;
      if (lat !== 3) begin
         bad++; $display("FAIL clamp_latency: got %0d want 3", lat);
      end
      for (int i = 0; i < N; i++) begin
         y = lane_val(got, i);
         total++;
         if (y !== 4096) begin
            bad++; $display("FAIL clamp lane %0d x=%0d: got %0d want 4096", i, lane_val(v, i), y);
         end
      end
   endtask

   task automatic test_back_to_back();
      int xs   [3] = '{0, -4096, -8192};
      int want [3] = '{4096, 1507, 554};
      logic [VW-1:0] got [3];
      int vc [3];
      int n, start, y;
      step();
      start = cyc;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         in_data  = fill(xs[k]);
         step();
      end
      in_valid = 1'b0;
      in_data  = random_vec();
      n = 0;
      for (int c = 0; c < 8; c++) begin
         if (out_valid === 1'b1) begin
            if (n < 3) begin
               got[n] = out_exp;
               vc[n]  = cyc - start;
            end
            n++;
         end
         step();
      end
      total++;
      if (n !== 3) begin
         bad++; $display("FAIL b2b_count: got %0d want 3", n);
      end else begin
         for (int k = 0; k < 3; k++) begin
            total++;
            if (vc[k] !== 3 + k) begin
               bad++; $display("FAIL b2b_cycle %0d: got %0d want %0d", k, vc[k], 3 + k);
            end
            for (int i = 0; i < N; i++) begin
               y = lane_val(got[k], i);
               total++;
               if (y < 0 || !near(y, real'(want[k])) || (k == 0 && y !== 4096)) begin
                  bad++; $display("FAIL b2b_value vec %0d lane %0d: got %0d want %0d", k, i, y, want[k]);
               end
            end
         end
         total++;
         if (out_exp !== got[2]) begin
            bad++; $display("FAIL b2b_hold: got %h want %h", out_exp, got[2]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int n, lat, y;
      logic [VW-1:0] got;
      step();
      in_valid = 1'b1;
      in_data  = fill(-4096);
      step();
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      total++;
      if (out_exp !== '0) begin
         bad++; $display("FAIL midreset_exp: got %h want 0", out_exp);
      end
      total++;
      if (out_valid !== 1'b0) begin
         bad++; $display("FAIL midreset_valid: got %b want 0", out_valid);
      end
      repeat (2) step();
      rst = 1'b0;
      n = 0;
      repeat (6) begin
         step();
         if (out_valid === 1'b1) n++;
      end
      total++;
      if (n !== 0) begin
         bad++; $display("FAIL midreset_dropped: got %0d pulses want 0", n);
      end
      send_one(fill(-2048), lat, got);
      total++;
      if (lat !== 3) begin
         bad++; $display("FAIL midreset_latency: got %0d want 3", lat);
      end
      for (int i = 0; i < N; i++) begin
         y = lane_val(got, i);
         total++;
         if (!near(y, ref_exp(-2048))) begin
            bad++; $display("FAIL midreset_value lane %0d: got %0d want 2484+/-2", i, y);
         end
      end
   endtask

   task automatic test_ramp();
      int prev, sent, x, y, dt;
      logic [VW-1:0] v, e;
      prev = -1;
      sent = 0;
      exp_q.delete();
      stamp_q.delete();
      step();
      for (int c = 0; c < 1025 + 12; c++) begin
         if (out_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++; $display("FAIL ramp_extra_valid: got 1 want 0 at cycle %0d", cyc);
            end else begin
               e  = exp_q.pop_front();
               dt = cyc - stamp_q.pop_front();
               if (dt !== 3) begin
                  bad++; $display("FAIL ramp_latency: got %0d want 3", dt);
               end
               for (int i = 0; i < N; i++) begin
                  x = lane_val(e, i);
                  y = lane_val(out_exp, i);
                  total++;
                  if (y < 0 || y > 4096 || !near(y, ref_exp(x)) || (x >= 0 && y !== 4096)) begin
                     bad++; $display("FAIL ramp_value x=%0d: got %0d want %f+/-2", x, y, ref_exp(x));
                  end
                  total++;
                  if (y < prev) begin
                     bad++; $display("FAIL ramp_monotonic x=%0d: got %0d want >= %0d", x, y, prev);
                  end
                  prev = y;
               end
            end
         end
         if (sent < 1025) begin
            for (int i = 0; i < N; i++) v[i*BW +: BW] = BW'(-32768 + sent * N + i);
            in_valid = 1'b1;
            in_data  = v;
            exp_q.push_back(v);
            stamp_q.push_back(cyc);
            sent++;
         end else begin
            in_valid = 1'b0;
            in_data  = random_vec();
         end
         step();
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++; $display("FAIL ramp_drain: got %0d pending want 0", exp_q.size());
      end
   endtask

   task automatic test_random();
      int x, y, dt;
      bit have_last;
      logic [VW-1:0] v, e, last;
      have_last = 1'b0;
      last = '0;
      exp_q.delete();
      stamp_q.delete();
      step();
      for (int c = 0; c < 400 + 12; c++) begin
         if (out_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++; $display("FAIL rand_extra_valid: got 1 want 0 at cycle %0d", cyc);
            end else begin
               e  = exp_q.pop_front();
               dt = cyc - stamp_q.pop_front();
               if (dt !== 3) begin
                  bad++; $display("FAIL rand_latency: got %0d want 3", dt);
               end
               for (int i = 0; i < N; i++) begin
                  x = lane_val(e, i);
                  y = lane_val(out_exp, i);
                  total++;
                  if (y < 0 || y > 4096 || !near(y, ref_exp(x)) || (x >= 0 && y !== 4096)) begin
                     bad++; $display("FAIL rand_value x=%0d: got %0d want %f+/-2", x, y, ref_exp(x));
                  end
               end
            end
            last = out_exp;
            have_last = 1'b1;
         end else if (have_last) begin
            total++;
            if (out_exp !== last) begin
               bad++; $display("FAIL rand_hold: got %h want %h", out_exp, last);
            end
         end
         if (c < 400 && $urandom_range(0, 99) < 60) begin
            for (int i = 0; i < N; i++) begin
               if ($urandom_range(0, 3) == 0) x = int'($urandom_range(0, 65535)) - 32768;
               else                           x = -int'($urandom_range(0, 32768));
               v[i*BW +: BW] = BW'(x);
            end
            in_valid = 1'b1;
            in_data  = v;
            exp_q.push_back(v);
            stamp_q.push_back(cyc);
         end else begin
            in_valid = 1'b0;
            in_data  = random_vec();
         end
         step();
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++; $display("FAIL rand_drain: got %0d pending want 0", exp_q.size());
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_zero();
      test_points();
      test_clamp();
      test_back_to_back();
      test_reset_mid();
      test_ramp();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

endmodule

// File: doc/exp_calculator_vec.md
EXP_CALCULATOR_VEC -- requirements
Module: exp_calculator_vec

Interface
REQ-001 Parameter N, default 32, number of parallel lanes.
REQ-002 Parameter BIT_WIDTH, default 16, lane word width.
REQ-003 i_clk  input  1  clock; all state updates on rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_valid  input  1  input vector valid, one cycle per vector.
REQ-006 i_data  input  signed BIT_WIDTH x N  lane operands x, Q4.12, nominally x = v - max(v) <= 0.
REQ-007 o_exp  output  signed BIT_WIDTH x N  per-lane exp(x), Q4.12, range 0..4096.
REQ-008 o_valid  output  1  single-cycle pulse, o_exp holds a new vector.

Function
REQ-009 Each lane SHALL compute o_exp[i] ~= round(4096*exp(i_data[i]/4096)), independent of other lanes.
REQ-010 Error SHALL be at most +/-2 LSB versus the real value over the input range -32768..0.
REQ-011 Input x > 0 SHALL be clamped to 0, so o_exp = 4096.
REQ-012 x = 0 SHALL give exactly 4096; results SHALL never be negative and never exceed 4096.
REQ-013 Output SHALL be monotonic non-decreasing in x within each lane.
REQ-014 Method: t = -x*log2(e), with log2(e) = 23637 in Q1.14 and the product shifted right by 14 to Q.12; k = integer part of t; f = fraction of t; result = 2^-f >> k, rounded to nearest.
REQ-015 2^-f SHALL use a 32-entry table of 2^(-j/32), unsigned Q1.16, with linear interpolation on the low 7 fraction bits; k >= 16 SHALL give 0.
REQ-016 Pipeline stage 1: clamp and log2(e) multiply.
REQ-017 Pipeline stage 2: split into k and f, table lookup and interpolation.
REQ-018 Pipeline stage 3: shift by k, round, drive the output register.
REQ-019 Latency: o_valid asserts exactly 3 cycles after i_valid, and the matching o_exp is presented in that same cycle.
REQ-020 The block is fully pipelined, accepts one vector per cycle, and has no backpressure or stall.
REQ-021 Back-to-back inputs SHALL produce back-to-back outputs in order.
REQ-022 Each stage's data registers SHALL load only when that stage's valid is set, and hold otherwise.
REQ-023 o_exp SHALL therefore keep the last result indefinitely until the next o_valid, because downstream normalization reads it many cycles later.
REQ-024 i_data SHALL be ignored when i_valid = 0.

Reset
REQ-025 While i_rst is asserted, o_valid, all internal valids, all pipeline data registers and o_exp SHALL be 0 immediately, without waiting for a clock edge.
REQ-026 Vectors in flight when reset asserts SHALL be dropped, with no o_valid for them.
REQ-027 The first i_valid after reset deassertion SHALL behave as in REQ-019.

Structure
REQ-028 A shared package SHALL hold:
- LOG2E_Q14 = 23637;
- the 32-entry EXP2 table;
- the Q-format fraction-bit constants (12, 14, 16).
REQ-029 One sub-module, exp_lane, SHALL hold the scalar 3-stage datapath with no valid logic.
REQ-030 exp_calculator_vec SHALL instantiate N copies of exp_lane and own the single valid shift register and lane enables.

Verification
REQ-031 All lanes 0, one i_valid pulse: exactly one o_valid 3 cycles later, all o_exp = 4096; o_exp still 4096 ten cycles later.
REQ-032 Lanes set to -2048, -4096, -8192, -32768: o_exp = 2484, 1507, 554, 1, each within +/-2 and >= 0.
REQ-033 Lanes +2048 and +32767: o_exp = 4096 on both.
REQ-034 Three consecutive vectors (all 0, all -4096, all -8192): o_valid high on 3 consecutive cycles with 4096, ~1507, ~554 in order; values then held.
REQ-035 Reset mid-operation: i_valid at cycle 0, i_rst asserted at cycle 1 -> no o_valid, o_exp = 0 immediately; the next vector after release completes normally.
REQ-036 Ramp sweep of x from -32768 to 0 across lanes and vectors: output monotonic non-decreasing and every lane within +/-2 LSB of the real model.
